// File: rtl/pe_col_issuer.sv
`default_nettype none
// ============================================================================
// Module   : pe_col_issuer
// Purpose  : Fetches a row's guard maps and issues one command per column
//            group to the PE column controller (valid/ready/finish).
//            Optional macro PE_ISSUER_SKIP_EMPTY_EN skips empty non-last groups.
// Revision : 1.0 - initial release
// ============================================================================
module pe_col_issuer #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              row_valid,
    output logic              row_ready,
    input  logic [ADDR_W-1:0] row_base,
    input  logic [LEN_W-1:0]  row_len,
    input  logic              row_bit_mode,
    input  logic              row_kernel_mode,
    input  logic              row_is_odd,
    output logic              map_rd_en,
    output logic [ADDR_W-1:0] map_rd_addr,
    input  logic [5:0]        map_rd_data,
    output logic              ctrl_valid,
    input  logic              ctrl_ready,
    input  logic              ctrl_finish,
    output logic [5:0]        guard_map_o,
    output logic              bit_mode_o,
    output logic              kernel_mode_o,
    output logic              is_odd_row_o,
    output logic              end_of_row_o,
    output logic              row_done,
    output logic              busy
`ifdef PE_ISSUER_SKIP_EMPTY_EN
   ,output logic [LEN_W-1:0]  skip_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_ISSUE = 3'd3,
        S_RUN   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [LEN_W-1:0] c_len_one = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_base;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_idx;
    logic [5:0]          r_guard_map;
    logic                r_bit_mode;
    logic                r_kernel_mode;
    logic                r_is_odd;
    logic                r_end_of_row;
    logic                w_accept;
    logic                w_capture;
    logic                w_skip;
    logic                w_cmd_done;
    logic                w_advance;
    logic                w_last;
    logic [ADDR_W-1:0]   w_idx_ext;

    assign w_last    = (r_idx == (r_len - c_len_one));
    assign w_idx_ext = ADDR_W'(r_idx);
    assign w_advance = (w_cmd_done && !w_last) || w_skip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_skip      = 1'b0;
        w_cmd_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (row_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (row_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_LATCH;
            S_LATCH: begin
                w_capture   = 1'b1;
                w_state_nxt = S_ISSUE;
`ifdef PE_ISSUER_SKIP_EMPTY_EN
                // The last group always goes out so end_of_row reaches the controller.
                if ((map_rd_data == 6'd0) && !r_bit_mode && !w_last) begin
                    w_skip      = 1'b1;
                    w_state_nxt = S_FETCH;
                end
`endif
            end
            S_ISSUE: begin
                if (ctrl_ready) begin
                    if (ctrl_finish) begin
                        w_cmd_done = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (ctrl_finish) begin
                    w_cmd_done = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_cmd_done) begin
            w_state_nxt = w_last ? S_DONE : S_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base        <= '0;
            r_len         <= '0;
            r_idx         <= '0;
            r_bit_mode    <= 1'b0;
            r_kernel_mode <= 1'b0;
            r_is_odd      <= 1'b0;
            r_guard_map   <= 6'd0;
            r_end_of_row  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_base        <= row_base;
                r_len         <= row_len;
                r_idx         <= '0;
                r_bit_mode    <= row_bit_mode;
                r_kernel_mode <= row_kernel_mode;
                r_is_odd      <= row_is_odd;
            end else if (w_advance) begin
                r_idx <= r_idx + c_len_one;
            end
            if (w_capture) begin
                r_guard_map  <= map_rd_data;
                r_end_of_row <= w_last;
            end
        end
    end

`ifdef PE_ISSUER_SKIP_EMPTY_EN
    logic [LEN_W-1:0] r_skip_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip_cnt <= '0;
        end else if (w_accept) begin
            r_skip_cnt <= '0;
        end else if (w_skip) begin
            r_skip_cnt <= r_skip_cnt + c_len_one;
        end
    end

    assign skip_cnt = r_skip_cnt;
`endif

    assign row_ready     = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign map_rd_en     = (r_state == S_FETCH);
    assign map_rd_addr   = map_rd_en ? (r_base + w_idx_ext) : '0;
    assign ctrl_valid    = (r_state == S_ISSUE);
    assign row_done      = (r_state == S_DONE);
    assign guard_map_o   = r_guard_map;
    assign bit_mode_o    = r_bit_mode;
    assign kernel_mode_o = r_kernel_mode;
    assign is_odd_row_o  = r_is_odd;
    assign end_of_row_o  = r_end_of_row;

endmodule
`default_nettype wire

// File: tb/tb_pe_col_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_col_issuer
// Purpose  : Randomized bench for pe_col_issuer against a cycle-timing
//            reference model of the row/command protocol.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_col_issuer;

    localparam int ADDR_W = 8;
    localparam int LEN_W  = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              row_valid = 1'b0;
    logic              row_ready;
    logic [ADDR_W-1:0] row_base = '0;
    logic [LEN_W-1:0]  row_len = '0;
    logic              row_bit_mode = 1'b0;
    logic              row_kernel_mode = 1'b0;
    logic              row_is_odd = 1'b0;
    logic              map_rd_en;
    logic [ADDR_W-1:0] map_rd_addr;
    logic [5:0]        map_rd_data = 6'd0;
    logic              ctrl_valid;
    logic              ctrl_ready = 1'b0;
    logic              ctrl_finish = 1'b0;
    logic [5:0]        guard_map_o;
    logic              bit_mode_o;
    logic              kernel_mode_o;
    logic              is_odd_row_o;
    logic              end_of_row_o;
    logic              row_done;
    logic              busy;
`ifdef PE_ISSUER_SKIP_EMPTY_EN
    logic [LEN_W-1:0]  skip_cnt;
    int                skips;
`endif

    pe_col_issuer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .row_valid(row_valid), .row_ready(row_ready), .row_base(row_base),
        .row_len(row_len), .row_bit_mode(row_bit_mode),
        .row_kernel_mode(row_kernel_mode), .row_is_odd(row_is_odd),
        .map_rd_en(map_rd_en), .map_rd_addr(map_rd_addr), .map_rd_data(map_rd_data),
        .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_finish(ctrl_finish),
        .guard_map_o(guard_map_o), .bit_mode_o(bit_mode_o),
        .kernel_mode_o(kernel_mode_o), .is_odd_row_o(is_odd_row_o),
        .end_of_row_o(end_of_row_o), .row_done(row_done), .busy(busy)
`ifdef PE_ISSUER_SKIP_EMPTY_EN
       ,.skip_cnt(skip_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous map buffer, one cycle read latency
    logic [5:0] mem [0:255];
    always @(posedge clk) if (map_rd_en) map_rd_data <= mem[map_rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state: timing derived from the row/group protocol rules
    bit         in_row, grp_active, hs_done, outstanding, want_row, aborted;
    int         t_fetch, t_done, t_fin, hs_cyc, k, stall_n, stall_left;
    int         ready_pct = 100;
    int         abort_in_run = 0;
    int         n_accepted = 0;
    int         n_done = 0;
    int         fin_q[$];
    logic [7:0] b_m, req_b;
    logic [6:0] len_m, req_l;
    logic       bm_m, km_m, odd_m, req_bm, req_km, req_odd;

    task automatic check_reset_outputs();
        check("rst_row_ready", 32'(row_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_map_rd", 32'({map_rd_en, map_rd_addr}), 32'd0);
        check("rst_ctrl_valid", 32'(ctrl_valid), 32'd0);
        check("rst_fields", 32'({guard_map_o, bit_mode_o, kernel_mode_o, is_odd_row_o, end_of_row_o}), 32'd0);
        check("rst_row_done", 32'(row_done), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        row_valid = 1'b0; ctrl_ready = 1'b0; ctrl_finish = 1'b0;
        #1;
        check_reset_outputs();
        in_row = 0; grp_active = 0; outstanding = 0; hs_done = 0; want_row = 0;
        aborted = 1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step();
        bit   exp_rd, exp_valid, exp_done, comp, fin;
        int   d;
        logic [7:0] a;
        @(negedge clk);
        if (abort_in_run != 0 && outstanding && cyc > hs_cyc) begin
            do_reset();
            return;
        end
        a         = 8'(b_m + k);
        exp_rd    = in_row && grp_active && (cyc == t_fetch);
        exp_valid = in_row && grp_active && !hs_done && (cyc >= t_fetch + 2);
        exp_done  = in_row && !grp_active && (cyc == t_done);
        check("busy", 32'(busy), 32'(in_row));
        check("row_ready", 32'(row_ready), 32'(!in_row));
        check("map_rd_en", 32'(map_rd_en), 32'(exp_rd));
        if (exp_rd) check("map_rd_addr", 32'(map_rd_addr), 32'(a));
        check("ctrl_valid", 32'(ctrl_valid), 32'(exp_valid));
        if (exp_valid)
            check("cmd_fields", 32'({guard_map_o, bit_mode_o, kernel_mode_o, is_odd_row_o, end_of_row_o}),
                  32'({mem[a], bm_m, km_m, odd_m, (k == int'(len_m) - 1)}));
        check("row_done", 32'(row_done), 32'(exp_done));
`ifdef PE_ISSUER_SKIP_EMPTY_EN
        if (exp_done) check("skip_cnt", 32'(skip_cnt), 32'(skips));
        if (in_row && grp_active && cyc == t_fetch + 1 && mem[a] == 6'd0 && !bm_m
            && k != int'(len_m) - 1) begin
            k++; t_fetch = cyc + 1; stall_left = stall_n; skips++;
        end
`endif
        // Controller side: ready, handshake and finish
        comp = 0; fin = 0;
        if (exp_valid && stall_left > 0) begin
            ctrl_ready = 1'b0;
            stall_left--;
        end else begin
            ctrl_ready = (int'($urandom_range(0, 99)) < ready_pct);
        end
        if (exp_valid && ctrl_ready) begin
            hs_done = 1; hs_cyc = cyc;
            d = (fin_q.size() > 0) ? fin_q.pop_front() : int'($urandom_range(0, 6));
            if (d == 0) begin fin = 1; comp = 1; end
            else begin outstanding = 1; t_fin = cyc + d; end
        end else if (outstanding && cyc == t_fin) begin
            fin = 1; comp = 1; outstanding = 0;
        end else if (!outstanding) begin
            fin = ($urandom_range(0, 7) == 0);
        end
        ctrl_finish = fin;
        if (comp) begin
            if (k == int'(len_m) - 1) begin
                grp_active = 0; t_done = cyc + 1;
            end else begin
                k++; t_fetch = cyc + 1; hs_done = 0; stall_left = stall_n;
            end
        end
        // Row side: offering in the row_done cycle must not be accepted
        row_valid = 1'b0;
        if (want_row && (!in_row || exp_done) && $urandom_range(0, 3) != 0) begin
            row_valid = 1'b1; row_base = req_b; row_len = req_l;
            row_bit_mode = req_bm; row_kernel_mode = req_km; row_is_odd = req_odd;
        end
        if (exp_done) begin
            in_row = 0; n_done++;
        end else if (row_valid && !in_row) begin
            in_row = 1; want_row = 0; n_accepted++;
            b_m = req_b; len_m = req_l; bm_m = req_bm; km_m = req_km; odd_m = req_odd;
            k = 0; hs_done = 0; outstanding = 0; stall_left = stall_n;
`ifdef PE_ISSUER_SKIP_EMPTY_EN
            skips = 0;
`endif
            if (req_l == 7'd0) begin grp_active = 0; t_done = cyc + 1; end
            else begin grp_active = 1; t_fetch = cyc + 1; end
        end
    endtask

    task automatic run_row(input logic [7:0] b, input logic [6:0] l,
                           input logic bm, input logic km, input logic odd);
        int acc0, done0, n;
        acc0 = n_accepted; done0 = n_done;
        req_b = b; req_l = l; req_bm = bm; req_km = km; req_odd = odd;
        want_row = 1; aborted = 0;
        for (n = 0; n < 3000; n++) begin
            step();
            if (aborted) break;
            if (n_accepted != acc0 && !in_row) break;
        end
        check("row_timeout", 32'(in_row || want_row), 32'd0);
        if (!aborted) check("row_done_count", 32'(n_done - done0), 32'd1);
        fin_q.delete();
        step();
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Nominal row with fixed finish delays
        mem[8'h10] = 6'h3F; mem[8'h11] = 6'h21; mem[8'h12] = 6'h01;
        ready_pct = 100; fin_q = '{6, 2, 1};
        run_row(8'h10, 7'd3, 1'b0, 1'b0, 1'b0);

        // Empty map, finish in the handshake cycle
        mem[8'h20] = 6'h00; mem[8'h21] = 6'h05;
        fin_q = '{0, 3};
        run_row(8'h20, 7'd2, 1'b0, 1'b1, 1'b0);

        // Backpressure of 5 cycles on every command
        stall_n = 5;
        run_row(8'h30, 7'd2, 1'b1, 1'b1, 1'b1);
        stall_n = 0;

        // Address wrap
        mem[8'hFE] = 6'h11; mem[8'hFF] = 6'h22; mem[8'h00] = 6'h33;
        run_row(8'hFE, 7'd3, 1'b0, 1'b0, 1'b1);

        mem[8'h40] = 6'h00; mem[8'h41] = 6'h00; mem[8'h42] = 6'h04; mem[8'h43] = 6'h00;
        run_row(8'h40, 7'd4, 1'b0, 1'b0, 1'b0);
        run_row(8'h40, 7'd4, 1'b1, 1'b0, 1'b0);

        run_row(8'h00, 7'd0, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            ready_pct = int'($urandom_range(30, 100));
            run_row(8'($urandom), 7'($urandom_range(0, 8)),
                    1'($urandom), 1'($urandom), 1'($urandom));
        end
        ready_pct = 100;

        // Reset while a command is running, then a clean zero-length row
        abort_in_run = 1; fin_q = '{8};
        run_row(8'h50, 7'd3, 1'b1, 1'b0, 1'b1);
        abort_in_run = 0;
        check("abort_taken", 32'(aborted), 32'd1);
        run_row(8'h00, 7'd0, 1'b0, 1'b0, 1'b0);
        run_row(8'h60, 7'd2, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_col_issuer.md
# pe_col_issuer

Command issuer for the PE column controller: accepts one row descriptor, reads that row's 6-bit guard maps from the sparsity-map buffer and issues one control command per column group over the ctrl valid/ready/finish interface. Sits between the layer sequencer and the PE column controller. Each command waits for `ctrl_finish` before the next is sent. `end_of_row` is flagged on the last group.

## Interface
Parameters:
- `ADDR_W`, 8: sparsity-map buffer address width.
- `LEN_W`, 7: width of the row-length field; a row holds at most 2^LEN_W−1 groups.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock.
  - `rst_n`  in  1  asynchronous active-low reset.
- Row descriptor input:
  - `row_valid`  in  1  row descriptor valid.
  - `row_ready`  out  1  issuer can accept a descriptor.
  - `row_base`  in  ADDR_W  map-buffer address of group 0.
  - `row_len`  in  LEN_W  number of groups in the row.
  - `row_bit_mode`, `row_kernel_mode`, `row_is_odd`  in  1 each  per-row mode bits.
- Map buffer read port (synchronous, 1-cycle latency):
  - `map_rd_en`  out  1  read strobe.
  - `map_rd_addr`  out  ADDR_W  read address.
  - `map_rd_data`  in  6  guard map; valid the cycle after `map_rd_en`.
- Command output to the column controller:
  - `ctrl_valid`  out  1  command valid.
  - `ctrl_ready`  in  1  controller can accept a command.
  - `ctrl_finish`  in  1  controller has completed the current command.
  - `guard_map_o`  out  6  guard map for the group.
  - `bit_mode_o`, `kernel_mode_o`, `is_odd_row_o`, `end_of_row_o`  out  1 each  command fields.
- Status:
  - `row_done`  out  1  one-cycle pulse when the row completes.
  - `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- State machine: IDLE → FETCH → LATCH → ISSUE → RUN → (FETCH | DONE) → IDLE.
- IDLE:
  - `row_ready`=1.
  - On `row_valid && row_ready`, register base, len and mode bits, clear the group index `idx`, go to FETCH.
  - If `row_len`==0, go to DONE instead.
- FETCH:
  - `map_rd_en`=1.
  - `map_rd_addr` = `base + idx`, modulo 2^ADDR_W, so the address wraps.
  - Go to LATCH.
- LATCH:
  - Capture `map_rd_data` into `guard_map_o`.
  - Set `end_of_row_o` = (`idx` == len−1).
  - Go to ISSUE.
- ISSUE:
  - `ctrl_valid`=1. All command fields are held stable while `ctrl_valid` is high.
  - Hold until `ctrl_valid && ctrl_ready`. `ctrl_ready` may deassert at any time, for example on FIFO full; the issuer keeps waiting.
  - On handshake, drop `ctrl_valid` in the next cycle.
  - If `ctrl_finish` is high in the handshake cycle (guard map 0 in non-bit mode), treat the command as complete immediately. Otherwise go to RUN.
- RUN:
  - Wait for `ctrl_finish`.
  - `ctrl_finish` is sampled only in RUN or in the ISSUE handshake cycle; at all other times it is ignored.
- Completion of a command:
  - If `idx` == len−1, go to DONE.
  - Otherwise increment `idx` and go to FETCH.
- DONE:
  - `row_done`=1 for exactly one cycle, then go to IDLE.
- Mode bits `bit_mode_o`, `kernel_mode_o` and `is_odd_row_o` are constant for the whole row. The guard map is forwarded raw; the controller applies dense forcing in bit mode.

## Timing
- Reset values:
  - `row_ready`=1.
  - `busy`=0.
  - All other outputs 0.
- Reset mid-row:
  - Immediate return to IDLE.
  - The in-flight command is abandoned.
  - No `row_done` is generated.
- Latency from row accept (cycle 0), with `ctrl_ready` held high:
  - `map_rd_en` in cycle 1.
  - `ctrl_valid` first high in cycle 3.
  - Handshake in cycle 3.
- Per-group overhead: 3 cycles from `ctrl_finish` to the next handshake (FETCH, LATCH, ISSUE).
- Row end: `row_done` in the cycle after the completion of the last command.
- Zero-length row: accept in cycle 0, `row_done` in cycle 1, no command and no read issued.
- A new row cannot be accepted in the `row_done` cycle; earliest next accept is the cycle after.

## Configuration
- Macro: `PE_ISSUER_SKIP_EMPTY_EN`.
- When defined:
  - In LATCH, a group with map==0 and row bit mode 0 is not issued when it is not the last group: increment `idx` and go straight to FETCH.
  - The last group is always issued so that `end_of_row` reaches the controller.
  - Adds a `skip_cnt` output (LEN_W): groups skipped in the current row, cleared on row accept.
- When undefined:
  - Every group is issued, including empty ones.
  - `skip_cnt` port is absent.

## Test plan
- Reset, then row base=0x10, len=3, maps 6'h3F, 6'h21, 6'h01, ready always 1, finish 6/2/1 cycles after each handshake:
  - Reads at addresses 0x10, 0x11, 0x12.
  - Three commands in order; `end_of_row_o`=1 only on the third.
  - `row_done` pulses once.
- Map 0 with bit_mode=0 and macro off:
  - `ctrl_finish` in the handshake cycle.
  - Next FETCH follows immediately with no RUN state.
- Backpressure: `ctrl_ready`=0 for 5 cycles during ISSUE:
  - `ctrl_valid` and all fields hold stable.
  - Handshake happens on the first ready=1.
- Address wrap: ADDR_W=8, base=0xFE, len=3 → read addresses 0xFE, 0xFF, 0x00.
- Macro on, maps 0, 0, 6'h04, 0 with len=4:
  - Commands issued only for groups 2 and 3; group 3 carries `end_of_row`.
  - `skip_cnt`=2.
- `rst_n` asserted while in RUN:
  - All outputs return to reset values.
  - A new row is accepted cleanly afterwards; len=0 gives `row_done` 1 cycle after accept.
